// File: rtl/screen_controller.sv
// Game-flow sequencer: START -> PLAY -> GAME_OVER. Selects the VGA source and issues the new-game pulse.
// Optional best-score tracking is enabled by defining HIGH_SCORE_EN.
module screen_controller #(
    parameter int HOLD_FRAMES = 60,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       key5IsPressed,
    input  logic [3:0] life,
    input  logic [3:0] score,
    input  logic [7:0] RGB_screen_main,
    input  logic [7:0] RGB_screen_start,
    input  logic [7:0] RGB_screen_end,
    output logic [7:0] RGB_out,
    output logic       start,
    output logic       game_over,
    output logic [3:0] final_score,
    output logic [3:0] high_score
);

    typedef enum logic [1:0] {
        ST_START     = 2'b00,
        ST_PLAY      = 2'b01,
        ST_GAME_OVER = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_FRAMES);

    state_t           state_q, state_d;
    logic             key_dly_q, key_dly_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]       final_score_q, final_score_d;
    logic             start_q, start_d;
    logic             game_over_q, game_over_d;
    logic [7:0]       rgb_out_q, rgb_out_d;
    logic             key_rise;

    assign key_rise = key5IsPressed & ~key_dly_q;

    always_comb begin
        state_d       = state_q;
        key_dly_d     = key5IsPressed;
        armed_d       = armed_q;
        frame_cnt_d   = frame_cnt_q;
        final_score_d = final_score_q;
        start_d       = 1'b0;

        case (state_q)
            ST_START: begin
                if (key_rise) begin
                    state_d = ST_PLAY;
                    start_d = 1'b1;
                    armed_d = 1'b0;
                end
            end
            ST_PLAY: begin
                // armed blocks a stale life==0 left over from the previous game
                if (life != 4'd0) begin
                    armed_d = 1'b1;
                end
                if (startOfFrame && armed_q && (life == 4'd0)) begin
                    state_d       = ST_GAME_OVER;
                    final_score_d = score;
                    frame_cnt_d   = '0;
                end
            end
            ST_GAME_OVER: begin
                if (startOfFrame && (frame_cnt_q < HOLD_CNT)) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
                if (key_rise && (frame_cnt_q == HOLD_CNT)) begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        game_over_d = (state_d == ST_GAME_OVER);
    end

    // Pixel source follows the registered state, so it switches one clock after a transition
    always_comb begin
        rgb_out_d = 8'd0;
        case (state_q)
            ST_START:     rgb_out_d = RGB_screen_start;
            ST_PLAY:      rgb_out_d = RGB_screen_main;
            ST_GAME_OVER: rgb_out_d = RGB_screen_end;
            default:      rgb_out_d = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_START;
            key_dly_q     <= 1'b0;
            armed_q       <= 1'b0;
            frame_cnt_q   <= '0;
            final_score_q <= 4'd0;
            start_q       <= 1'b0;
            game_over_q   <= 1'b0;
            rgb_out_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            key_dly_q     <= key_dly_d;
            armed_q       <= armed_d;
            frame_cnt_q   <= frame_cnt_d;
            final_score_q <= final_score_d;
            start_q       <= start_d;
            game_over_q   <= game_over_d;
            rgb_out_q     <= rgb_out_d;
        end
    end

    assign RGB_out     = rgb_out_q;
    assign start       = start_q;
    assign game_over   = game_over_q;
    assign final_score = final_score_q;

`ifdef HIGH_SCORE_EN
    logic [3:0] high_score_q, high_score_d;

    // Updated only on the PLAY -> GAME_OVER transition; a tie keeps the old best
    always_comb begin
        high_score_d = high_score_q;
        if ((state_q == ST_PLAY) && (state_d == ST_GAME_OVER) && (score > high_score_q)) begin
            high_score_d = score;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            high_score_q <= 4'd0;
        end else begin
            high_score_q <= high_score_d;
        end
    end

    assign high_score = high_score_q;
`else
    assign high_score = 4'd0;
`endif

endmodule

// File: tb/tb_screen_controller.sv
// Scoreboard bench for screen_controller: stimulus pushes expected outputs tagged with a cycle,
// a negedge monitor pops and compares them. Follows HIGH_SCORE_EN if defined.
module tb_screen_controller;

    localparam logic [7:0] RGB_START = 8'hA1;
    localparam logic [7:0] RGB_MAIN  = 8'hB2;
    localparam logic [7:0] RGB_END   = 8'hC3;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       key5IsPressed;
    logic [3:0] life;
    logic [3:0] score;
    logic [7:0] RGB_out;
    logic       start;
    logic       game_over;
    logic [3:0] final_score;
    logic [3:0] high_score;

    typedef struct {
        int         cycle;
        string      name;
        logic [7:0] rgb;
        logic       st;
        logic       go;
        logic [3:0] fs;
        logic [3:0] hs;
    } exp_t;

    exp_t       expQ[$];
    int         cycleCount = 0;
    int         checks = 0;
    int         passes = 0;
    logic [3:0] expFinal = 4'd0;
    logic [3:0] expHigh = 4'd0;

    screen_controller #(.HOLD_FRAMES(60), .CNT_W(8)) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .key5IsPressed    (key5IsPressed),
        .life             (life),
        .score            (score),
        .RGB_screen_main  (RGB_MAIN),
        .RGB_screen_start (RGB_START),
        .RGB_screen_end   (RGB_END),
        .RGB_out          (RGB_out),
        .start            (start),
        .game_over        (game_over),
        .final_score      (final_score),
        .high_score       (high_score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Sets inputs, then advances past the next rising edge that samples them
    task automatic applyStimulus(input logic key, input logic sof, input logic [3:0] lifeV,
                                 input logic [3:0] scoreV);
        key5IsPressed = key;
        startOfFrame  = sof;
        life          = lifeV;
        score         = scoreV;
        @(posedge clk);
        #1;
    endtask

    task automatic expectAt(input int offset, input string name, input logic [7:0] rgb,
                            input logic st, input logic go, input logic [3:0] fs,
                            input logic [3:0] hs);
        exp_t e;
        e.cycle = cycleCount + offset;
        e.name  = name;
        e.rgb   = rgb;
        e.st    = st;
        e.go    = go;
        e.fs    = fs;
        e.hs    = hs;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (RGB_out !== e.rgb || start !== e.st || game_over !== e.go ||
            final_score !== e.fs || high_score !== e.hs) begin
            $display("[TB] FAIL %s @cycle %0d: got rgb=%h start=%b go=%b fs=%0d hs=%0d, want rgb=%h start=%b go=%b fs=%0d hs=%0d",
                     e.name, cycleCount, RGB_out, start, game_over, final_score, high_score,
                     e.rgb, e.st, e.go, e.fs, e.hs);
        end else begin
            passes++;
        end
    endtask

    // Monitor: compare every entry due this cycle; late entries are reported as failures
    always @(negedge clk) begin
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].cycle == cycleCount) begin
                checkOutput(expQ[i]);
                expQ.delete(i);
            end else if (expQ[i].cycle < cycleCount) begin
                checks++;
                $display("[TB] FAIL %s: entry for cycle %0d missed, now %0d",
                         expQ[i].name, expQ[i].cycle, cycleCount);
                expQ.delete(i);
            end
        end
    end

    task automatic framePulses(input int n, input logic key, input logic [3:0] scoreV);
        for (int i = 0; i < n; i++) begin
            applyStimulus(key, 1'b1, 4'd0, scoreV);
            applyStimulus(key, 1'b0, 4'd0, scoreV);
        end
    endtask

    task automatic runGame(input logic [3:0] scoreV, input bit holdKey);
        expectAt(1, "start pulse", RGB_START, 1'b1, 1'b0, expFinal, expHigh);
        expectAt(2, "play rgb", RGB_MAIN, 1'b0, 1'b0, expFinal, expHigh);
        applyStimulus(1'b1, 1'b0, 4'd0, scoreV);
        applyStimulus(1'b0, 1'b0, 4'd0, scoreV);

        expectAt(1, "stale life ignored", RGB_MAIN, 1'b0, 1'b0, expFinal, expHigh);
        applyStimulus(1'b0, 1'b1, 4'd0, scoreV);
        applyStimulus(1'b0, 1'b0, 4'd3, scoreV);

        expFinal = scoreV;
`ifdef HIGH_SCORE_EN
        if (scoreV > expHigh) expHigh = scoreV;
`endif
        expectAt(1, "game over entry", RGB_MAIN, 1'b0, 1'b1, expFinal, expHigh);
        expectAt(2, "end rgb", RGB_END, 1'b0, 1'b1, expFinal, expHigh);
        applyStimulus(1'b1, 1'b1, 4'd0, scoreV);
        applyStimulus(1'b0, 1'b0, 4'd0, scoreV);

        framePulses(10, 1'b0, scoreV);
        expectAt(1, "early key ignored", RGB_END, 1'b0, 1'b1, expFinal, expHigh);
        applyStimulus(1'b1, 1'b0, 4'd0, scoreV);

        if (holdKey) begin
            framePulses(55, 1'b1, scoreV);
            expectAt(1, "held key no restart", RGB_END, 1'b0, 1'b1, expFinal, expHigh);
            applyStimulus(1'b1, 1'b0, 4'd0, scoreV);
            applyStimulus(1'b0, 1'b0, 4'd0, scoreV);
        end else begin
            applyStimulus(1'b0, 1'b0, 4'd0, scoreV);
            framePulses(49, 1'b0, scoreV);
            expectAt(1, "key at frame 59", RGB_END, 1'b0, 1'b1, expFinal, expHigh);
            applyStimulus(1'b1, 1'b0, 4'd0, scoreV);
            applyStimulus(1'b0, 1'b0, 4'd0, scoreV);
            framePulses(1, 1'b0, scoreV);
        end

        expectAt(1, "restart", RGB_END, 1'b0, 1'b0, expFinal, expHigh);
        expectAt(2, "start rgb", RGB_START, 1'b0, 1'b0, expFinal, expHigh);
        applyStimulus(1'b1, 1'b0, 4'd0, scoreV);
        applyStimulus(1'b0, 1'b0, 4'd0, scoreV);
    endtask

    initial begin
        resetN        = 1'b0;
        key5IsPressed = 1'b0;
        startOfFrame  = 1'b0;
        life          = 4'd0;
        score         = 4'd0;

        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        expectAt(0, "reset values", 8'd0, 1'b0, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        resetN = 1'b1;

        framePulses(3, 1'b0, 4'd0);
        expectAt(0, "idle start", RGB_START, 1'b0, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);

        runGame(4'd7, 1'b1);
        runGame(4'd3, 1'b0);
        runGame(4'd7, 1'b0);
        runGame(4'd9, 1'b0);

        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd3, 4'd0);
        resetN   = 1'b0;
        expFinal = 4'd0;
        expHigh  = 4'd0;
        expectAt(0, "async reset mid play", 8'd0, 1'b0, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd3, 4'd0);
        resetN = 1'b1;
        expectAt(1, "start after reset", RGB_START, 1'b0, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        expectAt(1, "start pulse after reset", RGB_START, 1'b1, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        end
        while (expQ.size() > 0) begin
            checks++;
            $display("[TB] FAIL %s: never compared (due cycle %0d)", expQ[0].name, expQ[0].cycle);
            void'(expQ.pop_front());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
